// File: rtl/spi_slave_driver_engine.sv
// SPI slave shift engine: oversampled pins, TX FIFO feeding MISO, MOSI capture.
// Define SPI_SLAVE_DRV_LSB_FIRST_EN for LSB-first shifting (MSB first otherwise).
module spi_slave_driver_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int TX_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = {DATA_WIDTH{1'b1}}
) (
   input  logic pclk,
   input  logic areset,
   input  logic cpol,
   input  logic cpha,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic miso,
   output logic miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic tx_valid,
   output logic tx_ready,
   output logic [$clog2(TX_DEPTH):0] tx_level,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic rx_valid,
   output logic underrun,
   output logic frame_err,
   output logic busy
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(TX_DEPTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state_q, state_d;

   logic [2:0] sclk_sy, cs_sy;
   logic [1:0] mosi_sy;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic cpol_l, cpha_l, lead, trail;
   logic in_shift, sample, shift, start, wrap, load, pop, push;
   logic [CW-1:0] cnt;
   logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next, load_word;
   logic [DATA_WIDTH-1:0] mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] level;
   logic fifo_empty, fifo_full;

`ifdef SPI_SLAVE_DRV_LSB_FIRST_EN
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return w[0];
   endfunction
   function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
      return {1'b0, w[DATA_WIDTH-1:1]};
   endfunction
   assign rx_next = {mosi_sy[1], rx_sr[DATA_WIDTH-1:1]};
`else
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-1];
   endfunction
   function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
      return {w[DATA_WIDTH-2:0], 1'b0};
   endfunction
   assign rx_next = {rx_sr[DATA_WIDTH-2:0], mosi_sy[1]};
`endif

   // cs_n syncs reset high so leaving reset never looks like a frame start
   always_ff @(posedge pclk) begin
      if (areset) begin
         sclk_sy <= '0;
         cs_sy <= '1;
         mosi_sy <= '0;
      end else begin
         sclk_sy <= {sclk_sy[1:0], sclk};
         cs_sy <= {cs_sy[1:0], cs_n};
         mosi_sy <= {mosi_sy[0], mosi};
      end
   end

   assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
   assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
   assign cs_rise = cs_sy[1] & ~cs_sy[2];
   assign cs_fall = ~cs_sy[1] & cs_sy[2];

   assign lead = cpol_l ? sclk_fall : sclk_rise;
   assign trail = cpol_l ? sclk_rise : sclk_fall;
   assign in_shift = (state_q == SHIFT) & ~cs_rise & ~cs_fall;
   assign sample = in_shift & (cpha_l ? trail : lead);
   assign shift = in_shift & (cpha_l ? lead : trail);
   assign start = (state_q == IDLE) & cs_fall;
   assign wrap = sample & (cnt == LAST_BIT);
   assign load = start | wrap;

   assign fifo_empty = (level == '0);
   assign fifo_full = (level == FULL_LVL);
   assign load_word = fifo_empty ? IDLE_PATTERN : mem[rd_ptr];
   assign pop = load & ~fifo_empty;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign push = tx_valid & (~fifo_full | pop);
   assign tx_ready = ~fifo_full;
   assign tx_level = level;

   always_ff @(posedge pclk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge pclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push & ~pop) level <= level + (AW+1)'(1);
         else if (pop & ~push) level <= level - (AW+1)'(1);
      end
   end

   always_ff @(posedge pclk) begin
      if (areset) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (cs_fall) state_d = SHIFT;
         SHIFT: if (cs_rise) state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      miso_oe = busy;
   end

   always_ff @(posedge pclk) begin
      if (areset) begin
         miso <= 1'b0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         frame_err <= 1'b0;
         cpol_l <= 1'b0;
         cpha_l <= 1'b0;
         cnt <= '0;
         tx_sr <= '0;
         rx_sr <= '0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= load & fifo_empty;
         frame_err <= 1'b0;
         if (start) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            cnt <= '0;
            if (cpha) begin
               tx_sr <= load_word;
            end else begin
               miso <= first_bit(load_word);
               tx_sr <= advance(load_word);
            end
         end else if ((state_q == SHIFT) & cs_rise) begin
            frame_err <= (cnt != '0);
            cnt <= '0;
         end else if (sample) begin
            rx_sr <= rx_next;
            if (wrap) begin
               rx_data <= rx_next;
               rx_valid <= 1'b1;
               cnt <= '0;
               tx_sr <= load_word;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (shift) begin
            miso <= first_bit(tx_sr);
            tx_sr <= advance(tx_sr);
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_driver_engine.sv
// Bench for spi_slave_driver_engine: bit-level SPI master plus a queue model
// of the TX FIFO and word loads, with directed and $urandom frames.
module tb_spi_slave_driver_engine;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int H = 6;
`ifdef SPI_SLAVE_DRV_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic pclk = 1'b0;
   logic areset, cpol, cpha, sclk, cs_n, mosi;
   logic miso, miso_oe, tx_ready, tx_valid;
   logic rx_valid, underrun, frame_err, busy;
   logic [DW-1:0] tx_data, rx_data;
   logic [2:0] tx_level;

   always #5 pclk = ~pclk;

   spi_slave_driver_engine dut (
      .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_level(tx_level), .rx_data(rx_data), .rx_valid(rx_valid),
      .underrun(underrun), .frame_err(frame_err), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   int un_n = 0;
   int fe_n = 0;
   logic [DW-1:0] rx_log[$];

   always @(negedge pclk) begin
      if (rx_valid) rx_log.push_back(rx_data);
      if (underrun) un_n++;
      if (frame_err) fe_n++;
   end

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_tx[4];
   logic [DW-1:0] m_rx[4];

   function automatic int bp(input int i);
      return LSB ? (i % DW) : (DW - 1 - (i % DW));
   endfunction

   task automatic push(input logic [DW-1:0] d);
      @(negedge pclk);
      check("tx_ready", tx_ready, mq.size() < DEPTH);
      if (mq.size() < DEPTH) begin
         tx_valid = 1'b1;
         tx_data = d;
         @(negedge pclk);
         tx_valid = 1'b0;
         mq.push_back(d);
      end
      check("tx_level", tx_level, mq.size());
   endtask

   task automatic xfer(input bit cp, input bit ch, input int nbits);
      cpol = cp;
      cpha = ch;
      sclk = cp;
      for (int w = 0; w < 4; w++) m_rx[w] = '0;
      repeat (8) @(negedge pclk);
      cs_n = 1'b0;
      if (!ch) mosi = m_tx[0][bp(0)];
      for (int i = 0; i < nbits; i++) begin
         repeat (H) @(negedge pclk);
         if (i == 0) begin
            check("busy_shift", busy, 1);
            check("miso_oe_shift", miso_oe, 1);
         end
         sclk = ~cp;
         if (ch) mosi = m_tx[i/DW][bp(i)];
         else m_rx[i/DW][bp(i)] = miso;
         repeat (H) @(negedge pclk);
         sclk = cp;
         if (ch) m_rx[i/DW][bp(i)] = miso;
         else if (i + 1 < nbits) mosi = m_tx[(i+1)/DW][bp(i+1)];
      end
      repeat (H) @(negedge pclk);
      cs_n = 1'b1;
   endtask

   task automatic hold_push(input logic [DW-1:0] d);
      bit seen;
      seen = 1'b0;
      tx_valid = 1'b1;
      tx_data = d;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge pclk);
         if (busy) seen = 1'b1;
      end
      tx_valid = 1'b0;
      check("full_pop_seen", seen, 1);
      check("tx_level_full", tx_level, DEPTH);
   endtask

   task automatic run_frame(input bit cp, input bit ch, input int nbits,
                            input bit fill, input logic [DW-1:0] fw);
      logic [DW-1:0] exp_tx[$];
      int eun, un0, fe0, rx0;
      eun = 0;
      for (int k = 0; k <= nbits / DW; k++) begin
         if (mq.size() > 0) exp_tx.push_back(mq.pop_front());
         else begin
            exp_tx.push_back({DW{1'b1}});
            eun++;
         end
         if (k == 0 && fill) mq.push_back(fw);
      end
      un0 = un_n;
      fe0 = fe_n;
      rx0 = rx_log.size();
      if (fill) begin
         fork
            xfer(cp, ch, nbits);
            hold_push(fw);
         join
      end else begin
         xfer(cp, ch, nbits);
      end
      repeat (10) @(negedge pclk);
      check("rx_count", rx_log.size() - rx0, nbits / DW);
      for (int w = 0; w < nbits / DW; w++) begin
         if (rx0 + w < rx_log.size())
            check("rx_data", rx_log[rx0+w], m_tx[w]);
         check("miso_word", m_rx[w], exp_tx[w]);
      end
      check("underrun", un_n - un0, eun);
      check("frame_err", fe_n - fe0, (nbits % DW) != 0);
      check("busy_idle", busy, 0);
      check("miso_oe_idle", miso_oe, 0);
      check("tx_level_end", tx_level, mq.size());
   endtask

   initial begin
      areset = 1'b1;
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      cpol = 1'b0;
      cpha = 1'b0;
      tx_valid = 1'b0;
      tx_data = '0;
      repeat (4) @(negedge pclk);
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_tx_level", tx_level, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_underrun", underrun, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      areset = 1'b0;
      repeat (4) @(negedge pclk);

      // mode 0 basic word; second word keeps the follow-on load fed
      push(8'hA5);
      push(8'h5A);
      m_tx[0] = 8'h3C;
      run_frame(0, 0, 8, 0, '0);

      for (int m = 0; m < 4; m++) begin
         push(8'h69);
         m_tx[0] = 8'h96;
         run_frame(m[1], m[0], 8, 0, '0);
      end

      push(8'h11);
      push(8'h22);
      push(8'h33);
      m_tx[0] = 8'hA1;
      m_tx[1] = 8'hB2;
      m_tx[2] = 8'hC3;
      run_frame(0, 0, 24, 0, '0);

      m_tx[0] = 8'($urandom);
      run_frame(1, 1, 8, 0, '0);

      push(8'h77);
      m_tx[0] = 8'hE1;
      run_frame(0, 1, 5, 0, '0);
      push(8'h88);
      m_tx[0] = 8'h4D;
      run_frame(0, 1, 8, 0, '0);

      // fill, refuse a fifth push, then push while the frame start pops
      for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
      m_tx[0] = 8'h12;
      run_frame(0, 0, 8, 1, 8'hE7);
      for (int w = 0; w < 4; w++) m_tx[w] = 8'($urandom);
      run_frame(1, 0, 32, 0, '0);

      push(8'h01);
      push(8'h02);
      areset = 1'b1;
      repeat (2) @(negedge pclk);
      areset = 1'b0;
      mq.delete();
      @(negedge pclk);
      check("rst2_tx_level", tx_level, 0);
      check("rst2_tx_ready", tx_ready, 1);

      for (int it = 0; it < 20; it++) begin
         int np;
         np = $urandom_range(0, 5);
         for (int p = 0; p < np; p++) push(8'($urandom));
         for (int w = 0; w < 4; w++) m_tx[w] = 8'($urandom);
         run_frame(1'($urandom), 1'($urandom), $urandom_range(1, 32), 0, '0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
